ntt_out_collector: RTL and testbench

Receives the per-core result bundle the router drives on its `out`/`address_out` ports and streams it to the host side one 30-bit coefficient per cycle. Uses a valid/ready handshake on both sides. Holds up to two complete snapshots (ping-pong), so the router can deliver the next bundle while the previous one drains. Sits between the router output and the host DMA/output FIFO.

---
 rtl/ntt_pkg.sv | 32 +++
 rtl/ntt_snapshot_bank.sv | 40 ++++
 rtl/ntt_out_collector.sv | 157 +++++++++++++++
 tb/tb_ntt_out_collector.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, pair-word type and index helpers for the
// NTT output collector (coefficient width, BRAM address width, bitrev).
package ntt_pkg;

    localparam int DATA_WIDTH = 30;
    localparam int ADDR_WIDTH = 9;

    // One BRAM pair word: high coefficient in the upper half.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] hi;
        logic [DATA_WIDTH-1:0] lo;
    } pair_t;

    // Width of a streamed coefficient index {address, core, slot, half}.
    function automatic int coef_idx_w(input int log_n);
        return ADDR_WIDTH + log_n + 2;
    endfunction

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v,
                                           input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_snapshot_bank.sv
// ntt_snapshot_bank: one registered snapshot of the router bundle
// (N cores x 2 pair words + address) with a word-select read mux.
// Ports: clk; i_cap capture enable; i_pairs / i_addr bundle in;
//        i_wc word counter {core, slot, half}; o_data / o_addr read out.
module ntt_snapshot_bank
    import ntt_pkg::*;
#(
    parameter  int LOG_N = 5,
    localparam int N     = 1 << LOG_N,
    localparam int WC_W  = LOG_N + 2
) (
    input  logic                             clk,
    input  logic                             i_cap,
    input  pair_t [N-1:0][1:0]               i_pairs,
    input  logic  [N-1:0][ADDR_WIDTH-1:0]    i_addr,
    input  logic  [WC_W-1:0]                 i_wc,
    output logic  [DATA_WIDTH-1:0]           o_data,
    output logic  [ADDR_WIDTH-1:0]           o_addr
);

    pair_t [N-1:0][1:0]            r_pairs;
    logic  [N-1:0][ADDR_WIDTH-1:0] r_addr;

    logic [LOG_N-1:0] w_core;
    pair_t            w_pair;

    // Storage needs no reset: the top only reads banks it has filled.
    always_ff @(posedge clk) begin
        if (i_cap) begin
            r_pairs <= i_pairs;
            r_addr  <= i_addr;
        end
    end

    assign w_core = i_wc[WC_W-1:2];
    assign w_pair = r_pairs[w_core][i_wc[1]];
    assign o_data = i_wc[0] ? w_pair.hi : w_pair.lo;
    assign o_addr = r_addr[w_core];

endmodule

// File: rtl/ntt_out_collector.sv
// ntt_out_collector: ping-pong capture of router result bundles, drained
// to the host as one coefficient per cycle over a valid/ready stream.
// Ports: clk, rst (sync, active high); in_valid/in_ready, in, address_in
//        bundle side; m_data, m_index, m_last, m_valid/m_ready stream side.
// Build option NTT_COLLECTOR_BITREV_EN: m_index is bit-reversed.
module ntt_out_collector
    import ntt_pkg::*;
#(
    parameter  int LOG_CORE_COUNT = 5,
    localparam int N              = 1 << LOG_CORE_COUNT,
    localparam int WC_W           = LOG_CORE_COUNT + 2,
    localparam int IDX_W          = coef_idx_w(LOG_CORE_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  pair_t [N-1:0][1:0]            in,
    input  logic  [N-1:0][ADDR_WIDTH-1:0] address_in,
    output logic  [DATA_WIDTH-1:0]        m_data,
    output logic  [IDX_W-1:0]             m_index,
    output logic                          m_last,
    output logic                          m_valid,
    input  logic                          m_ready
);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t          r_state;
    logic [1:0]      r_count;
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [WC_W-1:0] r_wc;

    logic                  w_cap;
    logic                  w_acc;
    logic                  w_is_last;
    logic                  w_done;
    logic                  w_load;
    logic                  w_next_bank;
    logic [WC_W-1:0]       w_next_wc;
    logic [DATA_WIDTH-1:0] w_data0;
    logic [DATA_WIDTH-1:0] w_data1;
    logic [ADDR_WIDTH-1:0] w_addr0;
    logic [ADDR_WIDTH-1:0] w_addr1;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [IDX_W-1:0]      w_idx_cat;
    logic [IDX_W-1:0]      w_idx;

    // Ready looks at occupancy only, so no path runs from m_ready.
    assign in_ready  = !rst && (r_count != 2'd2);
    assign w_cap     = in_valid && in_ready;
    assign w_acc     = (r_state == S_STREAM) && m_valid && m_ready;
    assign w_is_last = &r_wc;
    assign w_done    = w_acc && w_is_last;

    // r_wc is the word currently on the outputs; this picks the next one.
    always_comb begin
        w_next_wc   = r_wc;
        w_next_bank = r_rd_ptr;
        if (r_state == S_STREAM) begin
            if (w_is_last) begin
                w_next_wc   = '0;
                w_next_bank = ~r_rd_ptr;
            end else begin
                w_next_wc = r_wc + 1'b1;
            end
        end
    end

    // Continue straight into the other bank only if it was already full.
    always_comb begin
        w_load = 1'b0;
        unique case (r_state)
            S_IDLE:   w_load = (r_count != 2'd0);
            S_STREAM: w_load = w_acc && (!w_is_last || r_count == 2'd2);
            default:  w_load = 1'b0;
        endcase
    end

    ntt_snapshot_bank #(.LOG_N(LOG_CORE_COUNT)) u_bank0 (
        .clk     (clk),
        .i_cap   (w_cap && !r_wr_ptr),
        .i_pairs (in),
        .i_addr  (address_in),
        .i_wc    (w_next_wc),
        .o_data  (w_data0),
        .o_addr  (w_addr0)
    );

    ntt_snapshot_bank #(.LOG_N(LOG_CORE_COUNT)) u_bank1 (
        .clk     (clk),
        .i_cap   (w_cap && r_wr_ptr),
        .i_pairs (in),
        .i_addr  (address_in),
        .i_wc    (w_next_wc),
        .o_data  (w_data1),
        .o_addr  (w_addr1)
    );

    assign w_rd_data = w_next_bank ? w_data1 : w_data0;
    assign w_rd_addr = w_next_bank ? w_addr1 : w_addr0;
    assign w_idx_cat = {w_rd_addr, w_next_wc};

`ifdef NTT_COLLECTOR_BITREV_EN
    logic [31:0] w_rev;
    assign w_rev = bitrev(32'(w_idx_cat), IDX_W);
    assign w_idx = w_rev[IDX_W-1:0];
`else
    assign w_idx = w_idx_cat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_wc     <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_index  <= '0;
            m_last   <= 1'b0;
        end else begin
            if (w_cap) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_done) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_cap, w_done})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_acc) begin
                r_wc <= w_next_wc;
            end
            if (w_load) begin
                r_state <= S_STREAM;
                m_valid <= 1'b1;
                m_data  <= w_rd_data;
                m_index <= w_idx;
                m_last  <= &w_next_wc;
            end else if (w_done) begin
                r_state <= S_IDLE;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ntt_out_collector.sv
// tb_ntt_out_collector: directed bench for the NTT output collector,
// table of single-bundle streams plus ping-pong, overlap and reset cases.
module tb_ntt_out_collector;

    localparam int N  = 32;
    localparam int DW = 30;
    localparam int AW = 9;
    localparam int IW = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [N-1:0][1:0][59:0]   bus_in;
    logic [N-1:0][AW-1:0]      addr_in;
    logic [DW-1:0]             m_data;
    logic [IW-1:0]             m_index;
    logic                      m_last;
    logic                      m_valid;
    logic                      m_ready;

    always #5 clk = ~clk;

    ntt_out_collector #(.LOG_CORE_COUNT(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in         (bus_in),
        .address_in (addr_in),
        .m_data     (m_data),
        .m_index    (m_index),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    typedef struct {
        logic [29:0] d;
        logic [15:0] idx;
        logic        l;
    } exp_t;

    typedef struct {
        int          base;
        int          addr;
        int          step;
        bit          bp;
        logic [29:0] d0;
        logic [15:0] i0;
        logic [29:0] d127;
        logic [15:0] i127;
    } vec_t;

    int          n_pass = 0;
    int          n_tot  = 0;
    int          cyc    = 0;
    bit          bp     = 1'b0;
    bit          hold_pend = 1'b0;
    logic [47:0] held;
    exp_t        exp_q[$];

    int          acc_n, acc_first, acc_last, n_last;
    logic [29:0] fd, ld;
    logic [15:0] fi, li, i1;

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    function automatic logic [15:0] mk(input logic [15:0] v);
`ifdef NTT_COLLECTOR_BITREV_EN
        return rev16(v);
`else
        return v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    task automatic clr();
        acc_n = 0;
        n_last = 0;
        acc_first = 0;
        acc_last = 0;
    endtask

    // Runs at each falling edge: stability on stalls, ready choice,
    // scoreboard compare of the word accepted at the next rising edge.
    task automatic monitor();
        exp_t e;
        if (hold_pend)
            chk("hold", {m_valid, m_last, m_index, m_data}, held);
        m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        hold_pend = m_valid && !m_ready;
        held = {m_valid, m_last, m_index, m_data};
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_tot++;
                $display("FAIL extra: word %0h index %0h not expected",
                         m_data, m_index);
            end else begin
                e = exp_q.pop_front();
                chk("data", m_data, e.d);
                chk("index", m_index, e.idx);
                chk("last", m_last, e.l);
                if (acc_n == 0) begin
                    acc_first = cyc;
                    fd = m_data;
                    fi = m_index;
                end
                if (acc_n == 1) i1 = m_index;
                acc_last = cyc;
                ld = m_data;
                li = m_index;
                if (m_last) n_last++;
                acc_n++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic set_bundle(input int base, input int addr,
                              input int step);
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < 2; s++) begin
                bus_in[i][s] = {30'(base + 4*i + 2*s + 1),
                                30'(base + 4*i + 2*s)};
            end
            addr_in[i] = 9'(addr + i*step);
        end
    endtask

    task automatic push_bundle(input int base, input int addr,
                               input int step);
        exp_t e;
        logic [8:0] a;
        for (int k = 0; k < 4*N; k++) begin
            a = 9'(addr + (k/4)*step);
            e.d = 30'(base + k);
            e.idx = mk({a, 7'(k)});
            e.l = (k == 4*N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 3000 && exp_q.size() > 0; t++) cycle();
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic run_bundle(input vec_t v);
        clr();
        bp = v.bp;
        set_bundle(v.base, v.addr, v.step);
        in_valid = 1'b1;
        chk("cap_ready", in_ready, 1);
        cycle();
        in_valid = 1'b0;
        push_bundle(v.base, v.addr, v.step);
        chk("lat0", m_valid, 0);
        cycle();
        chk("lat1", m_valid, 1);
        drain("drain");
        chk("w0_data", fd, v.d0);
        chk("w0_index", fi, mk(v.i0));
        chk("w127_data", ld, v.d127);
        chk("w127_index", li, mk(v.i127));
        chk("last_count", n_last, 1);
        if (!v.bp) chk("full_rate", acc_last - acc_first, 127);
        bp = 1'b0;
        cycle();
        cycle();
        chk("idle_after", m_valid, 0);
    endtask

    vec_t vecs[5];
    int   bases[3];
    int   addrs[3];
    int   caps[3];
    int   b, last_a;
    bit   w, rdy_a, bad;

    initial begin
        vecs[0] = '{0, 10, 0, 1'b0, 30'd0, 16'h0500, 30'd127, 16'h057F};
        vecs[1] = '{0, 10, 0, 1'b1, 30'd0, 16'h0500, 30'd127, 16'h057F};
        vecs[2] = '{1000, 511, 0, 1'b1, 30'd1000, 16'hFF80,
                    30'd1127, 16'hFFFF};
        vecs[3] = '{32'h3FFFFF80, 0, 0, 1'b0, 30'h3FFFFF80, 16'h0000,
                    30'h3FFFFFFF, 16'h007F};
        vecs[4] = '{200, 3, 5, 1'b0, 30'd200, 16'h0180,
                    30'd327, 16'h4F7F};

        rst = 1'b1;
        in_valid = 1'b0;
        m_ready = 1'b0;
        set_bundle(0, 0, 0);
        cycle();
        cycle();
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_index", m_index, 0);
        chk("rst_last", m_last, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        cycle();
        chk("rel_in_ready", in_ready, 1);
        chk("rel_valid", m_valid, 0);

        for (int i = 0; i < 5; i++) begin
            run_bundle(vecs[i]);
            if (i == 0) begin
`ifdef NTT_COLLECTOR_BITREV_EN
                chk("w1_index", i1, 16'h80A0);
`else
                chk("w1_index", i1, 16'h0501);
`endif
            end
        end

        // Ping-pong: three bundles offered back to back.
        clr();
        bases = '{0, 128, 256};
        addrs = '{1, 2, 3};
        caps = '{-1, -1, -1};
        b = 0;
        last_a = -1;
        rdy_a = 1'b1;
        for (int t = 0; t < 3000 && (b < 3 || exp_q.size() > 0); t++) begin
            if (b < 3) begin
                set_bundle(bases[b], addrs[b], 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            w = in_ready && (b < 3);
            if (m_valid && m_ready && m_last && last_a < 0) begin
                last_a = cyc;
                rdy_a = in_ready;
            end
            caps[b < 3 ? b : 0] = w ? cyc : caps[b < 3 ? b : 0];
            cycle();
            if (w) begin
                push_bundle(bases[b], addrs[b], 0);
                b++;
            end
        end
        in_valid = 1'b0;
        chk("pp_drain", exp_q.size(), 0);
        chk("pp_back2back", caps[1] - caps[0], 1);
        chk("pp_ready_at_last", rdy_a, 0);
        chk("pp_cap3", caps[2] - last_a, 1);
        chk("pp_no_bubble", acc_last - acc_first, 383);
        chk("pp_lasts", n_last, 3);
        chk("pp_words", acc_n, 384);

        // Capture on the same edge as the m_last accept.
        clr();
        set_bundle(500, 7, 0);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        push_bundle(500, 7, 0);
        for (int t = 0; t < 1000 && !(m_valid && m_ready && m_last); t++)
            cycle();
        chk("sim_find", m_valid && m_ready && m_last, 1);
        set_bundle(700, 8, 1);
        in_valid = 1'b1;
        chk("sim_ready", in_ready, 1);
        cycle();
        in_valid = 1'b0;
        push_bundle(700, 8, 1);
        chk("sim_count1", in_ready, 1);
        drain("sim_drain");
        chk("sim_lasts", n_last, 2);
        chk("sim_first_new", li, mk({9'(8 + 31), 7'd127}));

        // Reset part way through a stream.
        clr();
        set_bundle(40, 4, 0);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        push_bundle(40, 4, 0);
        for (int t = 0; t < 1000 && exp_q.size() > 78; t++) cycle();
        chk("mid_words", acc_n, 50);
        rst = 1'b1;
        exp_q.delete();
        hold_pend = 1'b0;
        cycle();
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_valid", m_valid, 0);
        rst = 1'b0;
        cycle();
        chk("mid_rel_valid", m_valid, 0);
        chk("mid_rel_ready", in_ready, 1);
        bad = 1'b0;
        for (int t = 0; t < 5; t++) begin
            cycle();
            if (m_valid) bad = 1'b1;
        end
        chk("mid_quiet", bad, 0);
        run_bundle(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
